// File: rtl/mcycle_unit.sv
// Multi-cycle shift-add multiplier / restoring divider, one bit per cycle.
// Optional two's-complement support is enabled with `define MCYCLE_SIGNED_EN.
module mcycle_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             MCycleOp,
`ifdef MCYCLE_SIGNED_EN
  input  logic             Signed,
`endif
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COMPUTE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic               is_div_q;
  logic               neg_quo_q, neg_rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q, b_q;
  logic [WIDTH-1:0]   res1_q, res2_q;
  logic               done_q;

  logic               last_c;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sgn_a, sgn_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res1_d, res2_d;

  assign last_c  = (count_q == CW'(WIDTH - 1));
  assign Result1 = res1_q;
  assign Result2 = res2_q;
  assign Done    = done_q;

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (Start)  state_d = ST_COMPUTE;
      ST_COMPUTE: if (last_c) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Stall request: asserted in the accepting cycle so the issuer holds
  always_comb begin
    Busy = 1'b0;
    case (state_q)
      ST_IDLE:    Busy = Start;
      ST_COMPUTE: Busy = 1'b1;
      default:    Busy = 1'b0;
    endcase
  end

  // Operand magnitudes; a zero divisor keeps raw operands so the core yields ~0 / dividend
  always_comb begin
    mag_a = Operand1;
    mag_b = Operand2;
    sgn_a = 1'b0;
    sgn_b = 1'b0;
`ifdef MCYCLE_SIGNED_EN
    if (Signed && !(MCycleOp && (Operand2 == '0))) begin
      sgn_a = Operand1[WIDTH-1];
      sgn_b = Operand2[WIDTH-1];
    end
    if (sgn_a) mag_a = WIDTH'(-Operand1);
    if (sgn_b) mag_b = WIDTH'(-Operand2);
`endif
  end

  // One iteration: hi holds product-high / remainder, lo holds multiplier / quotient
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : (WIDTH+1)'(0));
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};
    if (is_div_q) begin
      hi_d = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied on the completion edge
  always_comb begin
    prod_fix = {hi_d, lo_d};
    if (neg_quo_q) prod_fix = (2*WIDTH)'(-prod_fix);
    if (is_div_q) begin
      res1_d = neg_quo_q ? WIDTH'(-lo_d) : lo_d;
      res2_d = neg_rem_q ? WIDTH'(-hi_d) : hi_d;
    end else begin
      res1_d = prod_fix[WIDTH-1:0];
      res2_d = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath and result registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      res1_q    <= '0;
      res2_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            count_q   <= '0;
            is_div_q  <= MCycleOp;
            neg_quo_q <= sgn_a ^ sgn_b;
            neg_rem_q <= sgn_a;
            hi_q      <= '0;
            lo_q      <= MCycleOp ? mag_a : mag_b;
            b_q       <= MCycleOp ? mag_b : mag_a;
          end
        end
        ST_COMPUTE: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          count_q <= count_q + CW'(1);
          if (last_c) begin
            count_q <= '0;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            done_q  <= 1'b1;
          end
        end
        default: count_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed cases plus randomized ops against an arithmetic model.
module tb_mcycle_unit;
  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         Start;
  logic         MCycleOp;
  logic         Signed;
  logic [W-1:0] Operand1, Operand2;
  logic [W-1:0] Result1, Result2;
  logic         Busy, Done;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp1 = '0;
  logic [W-1:0] exp2 = '0;

  always #5 CLK = ~CLK;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Start    (Start),
    .MCycleOp (MCycleOp),
`ifdef MCYCLE_SIGNED_EN
    .Signed   (Signed),
`endif
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference arithmetic
  function automatic void model(input bit op, input bit sg, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r1,
                                output logic [W-1:0] r2);
    logic [63:0] p;
    int sa, sb;
    if (!op) begin
      if (sg) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else    p = {32'd0, a} * {32'd0, b};
      r1 = p[31:0];
      r2 = p[63:32];
    end else if (b == 0) begin
      r1 = '1;
      r2 = a;
    end else if (!sg) begin
      r1 = a / b;
      r2 = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r1 = a;
      r2 = '0;
    end else begin
      sa = a;
      sb = b;
      r1 = sa / sb;
      r2 = sa % sb;
    end
  endfunction

  // Issue one op from the current cycle and follow it to its Done cycle
  task automatic run_op(input bit op, input bit sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke, input string tag);
    logic [W-1:0] m1, m2;
    int cyc, busy_gap, hold_err;
    model(op, sg, a, b, m1, m2);
    Start = 1'b1; MCycleOp = op; Signed = sg; Operand1 = a; Operand2 = b;
    #1;
    chk({tag, "_busy_start"}, 64'(Busy), 64'(1));
    @(posedge CLK); #1;
    Start = 1'b0; MCycleOp = ~op; Signed = ~sg;
    Operand1 = $urandom; Operand2 = $urandom;
    cyc = 0; busy_gap = 0; hold_err = 0;
    while (Done !== 1'b1 && cyc < int'(W) + 8) begin
      if (Busy !== 1'b1) busy_gap++;
      if (Result1 !== exp1 || Result2 !== exp2) hold_err++;
      Start = poke && (cyc == 3 || cyc == 20);
      @(posedge CLK); #1;
      cyc++;
    end
    Start = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(W));
    chk({tag, "_busy_held"}, 64'(busy_gap), 64'(0));
    chk({tag, "_result_hold"}, 64'(hold_err), 64'(0));
    chk({tag, "_done"}, 64'(Done), 64'(1));
    chk({tag, "_busy_done"}, 64'(Busy), 64'(0));
    chk({tag, "_r1"}, 64'(Result1), 64'(m1));
    chk({tag, "_r2"}, 64'(Result2), 64'(m2));
    exp1 = m1;
    exp2 = m2;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge CLK); #1;
    chk({tag, "_done_pulse"}, 64'(Done), 64'(0));
    chk({tag, "_busy_idle"}, 64'(Busy), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit rop, rsg;
    Reset = 1'b0; Start = 1'b0; MCycleOp = 1'b0; Signed = 1'b0;
    Operand1 = '0; Operand2 = '0;
    #3;
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_done", 64'(Done), 64'(0));
    chk("rst_r1", 64'(Result1), 64'(0));
    chk("rst_r2", 64'(Result2), 64'(0));
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;

    run_op(1'b0, 1'b0, 32'h0000_FFFF, 32'h0001_0001, 1'b0, "mul_ffff");
    idle_cycle("mul_ffff");
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_max");
    idle_cycle("mul_max");
    run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, "div_100_7");
    run_op(1'b1, 1'b0, 32'h0000_1234, 32'd0, 1'b0, "div_by_zero");
    idle_cycle("div_by_zero");
    run_op(1'b0, 1'b0, 32'd5, 32'd6, 1'b1, "mul_poke");
    idle_cycle("mul_poke");
    run_op(1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, "mul_zero");

    // Abort a divide with reset partway through
    Start = 1'b1; MCycleOp = 1'b1; Operand1 = 32'd1000; Operand2 = 32'd3;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    Reset = 1'b0;
    #1;
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_done", 64'(Done), 64'(0));
    chk("abort_r1", 64'(Result1), 64'(0));
    chk("abort_r2", 64'(Result2), 64'(0));
    @(posedge CLK); #1;
    Reset = 1'b1;
    exp1 = '0;
    exp2 = '0;
    run_op(1'b0, 1'b0, 32'd3, 32'd4, 1'b0, "mul_after_rst");
    idle_cycle("mul_after_rst");

`ifdef MCYCLE_SIGNED_EN
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "sdiv_m7_2");
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, "smul_m3_5");
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "sdiv_min_m1");
    run_op(1'b1, 1'b1, 32'hFFFF_FF00, 32'd0, 1'b0, "sdiv_zero");
`endif

    for (int i = 0; i < 20; i++) begin
      rop = 1'($urandom);
`ifdef MCYCLE_SIGNED_EN
      rsg = 1'($urandom);
`else
      rsg = 1'b0;
`endif
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_op(rop, rsg, ra, rb, 1'($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 1) == 1) idle_cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Multi-cycle multiply/divide responder for the processor datapath; the far end of the condition unit's MStart request.
- Accepts a conditioned start pulse with two operands and an op select, then iterates one bit per cycle.
- Holds Busy so the pipeline stalls, and pulses Done when Result1/Result2 are valid.
- Sits beside the ALU in the execute stage; results feed writeback.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- Start  input  1  start request (driven by MStart); sampled only in IDLE.
- MCycleOp  input  1  0 = multiply, 1 = divide; latched with Start.
- Operand1  input  WIDTH  multiplicand / dividend; latched with Start.
- Operand2  input  WIDTH  multiplier / divisor; latched with Start.
- Result1  output  WIDTH  multiply: product[WIDTH-1:0]; divide: quotient.
- Result2  output  WIDTH  multiply: product[2*WIDTH-1:WIDTH]; divide: remainder.
- Busy  output  1  stall request to the pipeline.
- Done  output  1  one-cycle pulse; results valid from this cycle.

Behaviour:
- Reset (Reset=0, async): state=IDLE; count=0; Result1=0, Result2=0, Done=0, Busy=0; internal operand/accumulator registers cleared. Reset mid-operation aborts with no partial result written.
- States: IDLE, COMPUTE.
- IDLE:
  - Start=1 latches operands and op.
  - Next state is COMPUTE with count=0.
- COMPUTE:
  - One iteration per edge.
  - After the WIDTH-th iteration edge, state returns to IDLE, Result1/Result2 load the final values, and Done is registered high for exactly one cycle.
- Latency: start edge E0 → Done high in the cycle after edge E_WIDTH (WIDTH cycles after the start edge).
- Busy (combinational) = (IDLE & Start) | COMPUTE.
  - Busy stalls the issuing instruction in the same cycle it asserts Start.
  - Busy is 0 in the Done cycle.
- Start while in COMPUTE is ignored.
- Start in the Done cycle (state already IDLE) is accepted: back-to-back operation.
  - Result registers keep the previous values until the next completion edge.
- Multiply:
  - Shift-add, unsigned.
  - 2*WIDTH accumulator, no truncation, no overflow flag.
- Divide:
  - Restoring division, unsigned.
  - WIDTH+1-bit partial remainder for the trial subtract.
- Divide by zero: Result1 = all ones, Result2 = Operand1. Same latency, no exception.
- Operands of 0 follow the normal path and full latency (no early termination).
- Result1/Result2 are registered and change only at the completion edge or on reset.

Optional Feature:
- Macro: MCYCLE_SIGNED_EN.
- Defined:
  - Adds input port Signed (1 bit), latched with Start.
  - When Signed=1, operands are two's complement. Magnitudes are computed up front, the unsigned core is reused, and result signs are fixed on the completion edge with no extra cycle.
  - Multiply: full 2*WIDTH signed product.
  - Divide: quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN/−1 gives Result1=MIN, Result2=0.
  - Divide by zero with Signed=1 gives Result1 = all ones, Result2 = Operand1.
- Undefined: Signed port is absent and all operations are unsigned. Identical latency either way.

Test Plan (WIDTH=32):
- MUL 0x0000FFFF × 0x00010001, Start one cycle:
  - Busy=1 from the Start cycle for 32 cycles.
  - Done pulses exactly once, 32 cycles after the start edge.
  - Result1=0xFFFFFFFF, Result2=0x00000000.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → Result1=0x00000001, Result2=0xFFFFFFFE.
- DIV 100 / 7 → Result1=14, Result2=2.
  - Immediately followed by Start in the Done cycle, DIV 0x1234 / 0: Result1 stays 14 until the second Done.
  - Then Result1=0xFFFFFFFF, Result2=0x00001234.
- Start toggled at iterations 3 and 20 of a MUL 5×6 → ignored; Result1=30 at the single Done.
- Reset driven low at iteration 10 of a DIV → Busy, Done, Result1 and Result2 go to 0 immediately.
  - After release, a fresh MUL 3×4 gives Result1=12 after 32 cycles.
- With MCYCLE_SIGNED_EN, Signed=1:
  - −7 / 2 → Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
  - −3 × 5 → Result1=0xFFFFFFF1, Result2=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → Result1=0x80000000, Result2=0.
